bd_word_splitter: RTL and testbench

- Parametrised splitter that turns one wide BD-side word (default 34 bits, as produced by the BD input bus) into a sequence of header-tagged 32-bit pipe words for the host PipeOut path.
- Generalises the fixed two-word {8'hFF, payload[23:0]} / {8'hFF, 14'd0, payload[33:24]} encoding to arbitrary input width, chunk width, header code and chunk order.
- Sits between the BD input deserialiser and the upstream PipeOut FIFO in the OK core.
- Ready/valid on both sides, sustaining one output word per cycle.

---
 rtl/bd_word_splitter.sv | 121 ++++++++++++
 tb/tb_bd_word_splitter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bd_word_splitter.sv
// Splits one wide input word into a sequence of header-tagged pipe words.
// Chunk order is selectable; the final chunk handshake can accept the next word with no bubble.
module bd_word_splitter #(
  parameter int                  IN_BITS    = 34,
  parameter int                  OUT_BITS   = 32,
  parameter int                  CHUNK_BITS = 24,
  parameter logic [OUT_BITS-1:0] HEADER     = OUT_BITS'(8'hFF),
  parameter bit                  LSB_FIRST  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_BITS-1:0]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [31:0]         words_sent,
  output logic                dbg_state
);

  localparam int NUM_CHUNKS = (IN_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_BITS;
  localparam int HDR_W      = OUT_BITS - CHUNK_BITS;

  localparam logic [HDR_W-1:0] HDR       = HEADER[HDR_W-1:0];
  localparam logic [IDX_W-1:0] FIRST_IDX = LSB_FIRST ? IDX_W'(0) : IDX_W'(NUM_CHUNKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = LSB_FIRST ? IDX_W'(NUM_CHUNKS - 1) : IDX_W'(0);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IN_BITS-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          words_sent_q, words_sent_d;

  logic [PAD_W-1:0]      hold_pad;
  logic [CHUNK_BITS-1:0] chunk_sel;
  logic                  send_last;

  // Bits above IN_BITS in the top chunk read as zero.
  assign hold_pad  = PAD_W'(hold_q);
  assign send_last = (state_q == SEND) && (idx_q == LAST_IDX);

  always_comb begin
    chunk_sel = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        chunk_sel = hold_pad[k*CHUNK_BITS +: CHUNK_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      idx_q        <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      idx_q        <= idx_d;
      words_sent_q <= words_sent_d;
    end
  end

  // Handshake: a word/chunk transfers on a rising edge where valid and ready are both high;
  // valid never depends on ready, and in_ready rises in SEND only while the final chunk leaves.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    idx_d        = idx_q;
    words_sent_d = words_sent_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = in_data;
          idx_d   = FIRST_IDX;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = send_last;
        out_data  = {HDR, chunk_sel};
        in_ready  = send_last && out_ready;
        if (out_ready) begin
          if (!send_last) begin
            idx_d = LSB_FIRST ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
          end else begin
            words_sent_d = words_sent_q + 32'd1;
            if (in_valid) begin
              hold_d = in_data;
              idx_d  = FIRST_IDX;
            end else begin
              idx_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign words_sent = words_sent_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bd_word_splitter.sv
// Directed and randomised-stall checks for bd_word_splitter in three configurations:
// default LSB-first, MSB-first, and single-chunk with a custom header.
module tb_bd_word_splitter;

  localparam int W = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // Default configuration
  logic [33:0] a_in_data;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_dbg_state;
  logic [31:0] a_out_data, a_words_sent;

  // MSB-first configuration
  logic [33:0] m_in_data;
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last, m_dbg_state;
  logic [31:0] m_out_data, m_words_sent;

  // Single-chunk configuration
  logic [23:0] s_in_data;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_dbg_state;
  logic [31:0] s_out_data, s_words_sent;

  bd_word_splitter dut_a (
    .clk(clk), .reset(reset),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_last(a_out_last), .words_sent(a_words_sent), .dbg_state(a_dbg_state)
  );

  bd_word_splitter #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset),
    .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_last(m_out_last), .words_sent(m_words_sent), .dbg_state(m_dbg_state)
  );

  bd_word_splitter #(.IN_BITS(24), .CHUNK_BITS(24), .HEADER(32'h0000_00A5)) dut_s (
    .clk(clk), .reset(reset),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last), .words_sent(s_words_sent), .dbg_state(s_dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [33:0] bb_w [3];
  logic [31:0] bb_e [6];
  logic [33:0] w;
  logic [W-1:0] e;
  logic [31:0] prev_data;
  logic        prev_last, prev_stall, in_hs;
  int          sent, got, stall_left, cycles;
  localparam int N_WORDS = 1000;

  initial begin
    bb_w = '{34'h0_1234_5678, 34'h3_FFFF_FFFF, 34'h1_0000_0001};
    bb_e = '{32'hFF345678, 32'hFF000012, 32'hFFFFFFFF, 32'hFF0003FF, 32'hFF000001, 32'hFF000100};

    reset = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    m_in_data = '0; m_in_valid = 1'b0; m_out_ready = 1'b0;
    s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_last", a_out_last, 0);
    check("rst_a_data", a_out_data, 0);
    check("rst_a_words", a_words_sent, 0);
    check("rst_a_state", a_dbg_state, 0);
    check("rst_m_valid", m_out_valid, 0);
    check("rst_s_valid", s_out_valid, 0);
    reset = 1'b0;
    #1;
    check("rel_a_in_ready", a_in_ready, 1);
    check("rel_m_in_ready", m_in_ready, 1);
    check("rel_s_in_ready", s_in_ready, 1);

    // MSB-first order
    @(negedge clk);
    m_in_data = 34'h2_ABCD_EF12; m_in_valid = 1'b1; m_out_ready = 1'b1;
    @(negedge clk);
    m_in_valid = 1'b0;
    #1;
    check("m_c0_valid", m_out_valid, 1);
    check("m_c0_data", m_out_data, 32'hFF0002AB);
    check("m_c0_last", m_out_last, 0);
    step();
    check("m_c1_data", m_out_data, 32'hFFCDEF12);
    check("m_c1_last", m_out_last, 1);
    check("m_c1_in_ready", m_in_ready, 1);
    step();
    check("m_done_valid", m_out_valid, 0);
    check("m_done_words", m_words_sent, 1);

    // Single chunk, sustained one word per cycle
    @(negedge clk);
    s_in_data = 24'h123456; s_in_valid = 1'b1; s_out_ready = 1'b1;
    step();
    check("s_w0_data", s_out_data, 32'hA5123456);
    check("s_w0_last", s_out_last, 1);
    check("s_w0_in_ready", s_in_ready, 1);
    s_in_data = 24'hABCDEF;
    step();
    check("s_w1_valid", s_out_valid, 1);
    check("s_w1_data", s_out_data, 32'hA5ABCDEF);
    check("s_w1_last", s_out_last, 1);
    s_in_data = 24'h000001;
    step();
    check("s_w2_valid", s_out_valid, 1);
    check("s_w2_data", s_out_data, 32'hA5000001);
    s_in_valid = 1'b0;
    step();
    check("s_done_valid", s_out_valid, 0);
    check("s_done_words", s_words_sent, 3);

    // Default config with a three-cycle stall on the first chunk
    @(negedge clk);
    a_in_data = 34'h2_ABCD_EF12; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("a_stall_valid", a_out_valid, 1);
      check("a_stall_data", a_out_data, 32'hFFCDEF12);
      check("a_stall_last", a_out_last, 0);
      check("a_stall_in_ready", a_in_ready, 0);
      if (i < 2) step();
    end
    a_out_ready = 1'b1;
    #1;
    check("a_c0_in_ready", a_in_ready, 0);
    step();
    check("a_c1_data", a_out_data, 32'hFF0002AB);
    check("a_c1_last", a_out_last, 1);
    check("a_c1_in_ready", a_in_ready, 1);
    step();
    check("a_done_valid", a_out_valid, 0);
    check("a_done_words", a_words_sent, 1);

    // Three words back to back: six output cycles with no gap
    @(negedge clk);
    a_in_data = bb_w[0]; a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("bb_valid", a_out_valid, 1);
      check("bb_data", a_out_data, bb_e[i]);
      check("bb_last", a_out_last, (i % 2 == 1) ? 1 : 0);
      check("bb_in_ready", a_in_ready, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) begin
        if (i / 2 + 1 < 3) a_in_data = bb_w[i / 2 + 1];
        else a_in_valid = 1'b0;
      end
    end
    step();
    check("bb_done_valid", a_out_valid, 0);
    check("bb_done_words", a_words_sent, 4);

    // Reset after the first chunk has been accepted
    @(negedge clk);
    a_in_data = 34'h3_FFFF_FFFF; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    check("rm_c0_data", a_out_data, 32'hFFFFFFFF);
    step();
    check("rm_c1_data", a_out_data, 32'hFF0003FF);
    reset = 1'b1;
    #1;
    check("rm_valid", a_out_valid, 0);
    check("rm_data", a_out_data, 0);
    check("rm_words", a_words_sent, 0);
    step();
    check("rm_hold_valid", a_out_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rm_post_valid", a_out_valid, 0);
    end
    a_in_data = 34'h2_ABCD_EF12; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    check("rm_n0_data", a_out_data, 32'hFFCDEF12);
    check("rm_n0_last", a_out_last, 0);
    step();
    check("rm_n1_data", a_out_data, 32'hFF0002AB);
    check("rm_n1_last", a_out_last, 1);
    step();
    check("rm_n_words", a_words_sent, 1);

    // Random words with random stalls against the scoreboard
    sent = 0; got = 0; stall_left = 0; cycles = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; in_hs = 1'b0;
    w = '0;
    while (got < N_WORDS && cycles < 90000) begin
      @(negedge clk);
      cycles++;
      if (prev_stall) begin
        check("stall_data", a_out_data, prev_data);
        check("stall_last", a_out_last, prev_last);
      end
      if (in_hs) a_in_valid = 1'b0;
      if (!a_in_valid && sent < N_WORDS && $urandom_range(0, 3) != 0) begin
        w = {2'($urandom_range(0, 3)), $urandom()};
        a_in_data = w;
        a_in_valid = 1'b1;
      end
      if (stall_left > 0) begin
        a_out_ready = 1'b0;
        stall_left--;
      end else begin
        a_out_ready = 1'b1;
        if ($urandom_range(0, 3) == 0)
          stall_left = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 200) : $urandom_range(1, 3);
      end
      #1;
      in_hs = a_in_valid && a_in_ready;
      if (a_out_valid && a_out_ready) begin
        check("sb_underflow", exp_q.size() == 0, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_data", a_out_data, e[31:0]);
          check("sb_last", a_out_last, e[32]);
          if (a_out_last) got++;
        end
      end
      if (in_hs) begin
        exp_q.push_back({1'b0, 8'hFF, w[23:0]});
        exp_q.push_back({1'b1, 8'hFF, 14'd0, w[33:24]});
        sent++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
      prev_last  = a_out_last;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    check("rand_words_done", got, N_WORDS);
    check("rand_sb_empty", exp_q.size(), 0);
    step();
    check("rand_words_sent", a_words_sent, 1 + N_WORDS);
    check("rand_idle", a_out_valid, 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
